// File: rtl/butterfly_if.sv
// Operand/result bundle for the radix-2 butterfly: start qualifies x1, x2 and w,
// done marks a fresh y1/y2 pair.
interface butterfly_if #(
   parameter int DATA_W = 16
);
   logic              start;
   logic [DATA_W-1:0] x1_r;
   logic [DATA_W-1:0] x1_i;
   logic [DATA_W-1:0] x2_r;
   logic [DATA_W-1:0] x2_i;
   logic [DATA_W-1:0] w_r;
   logic [DATA_W-1:0] w_i;
   logic [DATA_W-1:0] y1_r;
   logic [DATA_W-1:0] y1_i;
   logic [DATA_W-1:0] y2_r;
   logic [DATA_W-1:0] y2_i;
   logic              done;

   modport master (
      output start, x1_r, x1_i, x2_r, x2_i, w_r, w_i,
      input  y1_r, y1_i, y2_r, y2_i, done
   );

   modport slave (
      input  start, x1_r, x1_i, x2_r, x2_i, w_r, w_i,
      output y1_r, y1_i, y2_r, y2_i, done
   );
endinterface

// File: rtl/butterfly.sv
// Two-stage pipelined radix-2 DIT butterfly: y1 = x1 + W*x2, y2 = x1 - W*x2,
// fixed point with round-half-up on the twiddle product and saturating results.
module butterfly #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8
) (
   input logic       clk,
   input logic       rst_n,
   butterfly_if.slave bus
);
   localparam int PW = 2 * DATA_W + 1;
   localparam int SW = DATA_W + 2;
   localparam logic signed [PW-1:0] ROUND   = PW'(2 ** (FRAC_W - 1));
   localparam logic signed [SW-1:0] SAT_MAX = SW'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

   logic signed [PW-1:0] prod_rr;
   logic signed [PW-1:0] prod_ii;
   logic signed [PW-1:0] prod_ri;
   logic signed [PW-1:0] prod_ir;
   logic signed [PW-1:0] pr_biased;
   logic signed [PW-1:0] pi_biased;
   logic signed [SW-1:0] t_r_next;
   logic signed [SW-1:0] t_i_next;

   logic                 valid_q;
   logic signed [DATA_W-1:0] x1_r_q;
   logic signed [DATA_W-1:0] x1_i_q;
   logic signed [SW-1:0] t_r_q;
   logic signed [SW-1:0] t_i_q;

   logic signed [SW-1:0] sum_r;
   logic signed [SW-1:0] sum_i;
   logic signed [SW-1:0] dif_r;
   logic signed [SW-1:0] dif_i;

   logic                 done_q;
   logic [DATA_W-1:0]    y1_r_q;
   logic [DATA_W-1:0]    y1_i_q;
   logic [DATA_W-1:0]    y2_r_q;
   logic [DATA_W-1:0]    y2_i_q;

   function automatic logic [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
      if (v > SAT_MAX) begin
         return SAT_MAX[DATA_W-1:0];
      end else if (v < SAT_MIN) begin
         return SAT_MIN[DATA_W-1:0];
      end else begin
         return v[DATA_W-1:0];
      end
   endfunction

   // Exact complex product at full width; the rounding bias is folded in before the shift.
   always_comb begin
      prod_rr   = PW'($signed(bus.x2_r)) * PW'($signed(bus.w_r));
      prod_ii   = PW'($signed(bus.x2_i)) * PW'($signed(bus.w_i));
      prod_ri   = PW'($signed(bus.x2_r)) * PW'($signed(bus.w_i));
      prod_ir   = PW'($signed(bus.x2_i)) * PW'($signed(bus.w_r));
      pr_biased = prod_rr - prod_ii + ROUND;
      pi_biased = prod_ri + prod_ir + ROUND;
      t_r_next  = SW'(pr_biased >>> FRAC_W);
      t_i_next  = SW'(pi_biased >>> FRAC_W);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         x1_r_q  <= '0;
         x1_i_q  <= '0;
         t_r_q   <= '0;
         t_i_q   <= '0;
      end else begin
         valid_q <= bus.start;
         if (bus.start) begin
            x1_r_q <= $signed(bus.x1_r);
            x1_i_q <= $signed(bus.x1_i);
            t_r_q  <= t_r_next;
            t_i_q  <= t_i_next;
         end
      end
   end

   always_comb begin
      sum_r = SW'(x1_r_q) + t_r_q;
      sum_i = SW'(x1_i_q) + t_i_q;
      dif_r = SW'(x1_r_q) - t_r_q;
      dif_i = SW'(x1_i_q) - t_i_q;
   end

   // Results only move when stage 1 held a valid butterfly, so y holds while done is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
         y1_r_q <= '0;
         y1_i_q <= '0;
         y2_r_q <= '0;
         y2_i_q <= '0;
      end else begin
         done_q <= valid_q;
         if (valid_q) begin
            y1_r_q <= sat(sum_r);
            y1_i_q <= sat(sum_i);
            y2_r_q <= sat(dif_r);
            y2_i_q <= sat(dif_i);
         end
      end
   end

   assign bus.done = done_q;
   assign bus.y1_r = y1_r_q;
   assign bus.y1_i = y1_i_q;
   assign bus.y2_r = y2_r_q;
   assign bus.y2_i = y2_i_q;
endmodule

// File: tb/tb_butterfly.sv
// Directed bench for butterfly: hand-computed Q8.8 vectors covering latency,
// saturation, rounding, handshake, back-to-back flow and in-flight reset.
module tb_butterfly;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   butterfly_if #(.DATA_W(16)) bus ();

   butterfly #(.DATA_W(16), .FRAC_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // All four results packed as {y1_r, y1_i, y2_r, y2_i}.
   wire [63:0] y_all = {bus.y1_r, bus.y1_i, bus.y2_r, bus.y2_i};

   task automatic set_inputs(input logic [15:0] a_r, a_i, b_r, b_i, c_r, c_i);
      bus.x1_r = a_r;
      bus.x1_i = a_i;
      bus.x2_r = b_r;
      bus.x2_i = b_i;
      bus.w_r  = c_r;
      bus.w_i  = c_i;
   endtask

   // One start pulse, then junk on the inputs; returns just after the edge that presents y.
   task automatic fire(input logic [15:0] a_r, a_i, b_r, b_i, c_r, c_i);
      set_inputs(a_r, a_i, b_r, b_i, c_r, c_i);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      set_inputs(16'h5A5A, 16'hA5A5, 16'h7123, 16'h8ABC, 16'h3C3C, 16'hC3C3);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      bus.start = 1'b0;
      set_inputs(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      rst_n = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (y_all !== 64'h0) begin
         errors++;
         $display("[TB] FAIL reset_y got %h expected %h", y_all, 64'h0);
      end
      checks++;
      if (bus.done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_done got %b expected 0", bus.done);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_idle_done got %b expected 0", bus.done);
      end
   endtask

   task automatic test_nominal;
      fire(16'hFC00, 16'h0000, 16'h0200, 16'h0000, 16'h00B5, 16'hFF4B);
      checks++;
      if (y_all !== 64'hFD6A_FE96_FA96_016A) begin
         errors++;
         $display("[TB] FAIL nominal_y got %h expected %h", y_all, 64'hFD6A_FE96_FA96_016A);
      end
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL nominal_done got %b expected 1", bus.done);
      end
   endtask

   task automatic test_complex_twiddle;
      // (2 - 1j) +/- (1 + 1j)(0.5 + 0.25j) = (2 - 1j) +/- (0.25 + 0.75j)
      fire(16'h0200, 16'hFF00, 16'h0100, 16'h0100, 16'h0080, 16'h0040);
      checks++;
      if (y_all !== 64'h0240_FFC0_01C0_FE40) begin
         errors++;
         $display("[TB] FAIL complex_y got %h expected %h", y_all, 64'h0240_FFC0_01C0_FE40);
      end
   endtask

   task automatic test_pulse_hold;
      fire(16'h0100, 16'h0200, 16'h0080, 16'hFF80, 16'h0100, 16'h0000);
      checks++;
      if (y_all !== 64'h0180_0180_0080_0280) begin
         errors++;
         $display("[TB] FAIL identity_y got %h expected %h", y_all, 64'h0180_0180_0080_0280);
      end
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL identity_done got %b expected 1", bus.done);
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_done[%0d] got %b expected 0", k, bus.done);
         end
         checks++;
         if (y_all !== 64'h0180_0180_0080_0280) begin
            errors++;
            $display("[TB] FAIL hold_y[%0d] got %h expected %h", k, y_all, 64'h0180_0180_0080_0280);
         end
      end
   endtask

   task automatic test_saturation;
      fire(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0100, 16'h0000);
      checks++;
      if (y_all !== 64'h7FFF_7FFF_0000_0000) begin
         errors++;
         $display("[TB] FAIL sat_pos_y got %h expected %h", y_all, 64'h7FFF_7FFF_0000_0000);
      end
      fire(16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0100, 16'h0000);
      checks++;
      if (y_all !== 64'hFFFF_FFFF_8000_8000) begin
         errors++;
         $display("[TB] FAIL sat_neg_y got %h expected %h", y_all, 64'hFFFF_FFFF_8000_8000);
      end
   endtask

   task automatic test_rounding;
      // +0.5 LSB rounds up to 1 on both the real and imaginary products
      fire(16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0080, 16'h0000);
      checks++;
      if (y_all !== 64'h0001_0001_FFFF_FFFF) begin
         errors++;
         $display("[TB] FAIL round_half_up_y got %h expected %h", y_all, 64'h0001_0001_FFFF_FFFF);
      end
      // -0.5 LSB rounds toward +infinity, i.e. to 0
      fire(16'h0100, 16'h0000, 16'hFFFF, 16'h0000, 16'h0080, 16'h0000);
      checks++;
      if (y_all !== 64'h0100_0000_0100_0000) begin
         errors++;
         $display("[TB] FAIL round_neg_half_y got %h expected %h", y_all, 64'h0100_0000_0100_0000);
      end
      // -1.5 LSB rounds to -1
      fire(16'h0000, 16'h0000, 16'hFFFD, 16'h0000, 16'h0080, 16'h0000);
      checks++;
      if (y_all !== 64'hFFFF_0000_0001_0000) begin
         errors++;
         $display("[TB] FAIL round_neg_1p5_y got %h expected %h", y_all, 64'hFFFF_0000_0001_0000);
      end
   endtask

   task automatic test_reset_in_flight;
      set_inputs(16'hFC00, 16'h0000, 16'h0200, 16'h0000, 16'h00B5, 16'hFF4B);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (y_all !== 64'h0) begin
         errors++;
         $display("[TB] FAIL flight_reset_y got %h expected %h", y_all, 64'h0);
      end
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flight_done[%0d] got %b expected 0", k, bus.done);
         end
      end
      checks++;
      if (y_all !== 64'h0) begin
         errors++;
         $display("[TB] FAIL flight_after_y got %h expected %h", y_all, 64'h0);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] w_tab[3];
      logic [63:0] exp_tab[3];
      w_tab   = '{16'h0010, 16'h0020, 16'h0030};
      exp_tab = '{64'h0110_0010_00F0_0010, 64'h0120_0010_00E0_0010, 64'h0130_0010_00D0_0010};
      set_inputs(16'h0100, 16'h0010, 16'h0100, 16'h0000, w_tab[0], 16'h0000);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_fill_done got %b expected 0", bus.done);
      end
      for (int k = 0; k < 3; k++) begin
         if (k < 2) begin
            bus.w_r = w_tab[k + 1];
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         #1;
         checks++;
         if (y_all !== exp_tab[k]) begin
            errors++;
            $display("[TB] FAIL b2b_y[%0d] got %h expected %h", k, y_all, exp_tab[k]);
         end
         checks++;
         if (bus.done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_done[%0d] got %b expected 1", k, bus.done);
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_drain_done got %b expected 0", bus.done);
      end
   endtask

   initial begin
      test_reset;
      test_nominal;
      test_complex_twiddle;
      test_pulse_hold;
      test_saturation;
      test_rounding;
      test_reset_in_flight;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/butterfly.md
BUTTERFLY -- requirements
Module: butterfly

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: width of every data, twiddle and result port, two's complement.
REQ-002 The block SHALL have parameter FRAC_W, default 8: fractional bits of every data and twiddle port (Q8.8 at defaults; 0x0100 = 1.0).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: input-valid qualifier, sampled each rising edge.
REQ-006 The block SHALL have ports x1_r and x1_i, input, DATA_W bits: real and imaginary parts of the first operand.
REQ-007 The block SHALL have ports x2_r and x2_i, input, DATA_W bits: real and imaginary parts of the second operand.
REQ-008 The block SHALL have ports w_r and w_i, input, DATA_W bits: real and imaginary parts of the twiddle factor W.
REQ-009 The block SHALL have ports y1_r and y1_i, output, DATA_W bits: registered X1 + W*X2.
REQ-010 The block SHALL have ports y2_r and y2_i, output, DATA_W bits: registered X1 - W*X2.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle flag marking new y values.

Function
REQ-012 Stage 1 SHALL form the exact products on a rising edge where start=1. Products: pr = x2_r*w_r - x2_i*w_i and pi = x2_r*w_i + x2_i*w_r. Width: 2*DATA_W+1 signed bits, no overflow. The stage SHALL also register x1_r and x1_i alongside the products.
REQ-013 Stage 1 SHALL round each product to DATA_W+2 bits as (p + 2^(FRAC_W-1)) arithmetically shifted right by FRAC_W, i.e. round half toward +infinity.
REQ-014 Stage 2 SHALL compute the four results from the rounded products: y1 = x1 + t and y2 = x1 - t, real and imaginary separately. The stage SHALL use DATA_W+2 bits and register the results into the y ports.
REQ-015 Each result SHALL saturate to the DATA_W signed range: above max becomes 0x7FFF and below min becomes 0x8000 (defaults); no wrap-around.
REQ-016 Latency SHALL be 2 cycles. Inputs sampled with start=1 at edge N appear on the y ports after edge N+1, and done=1 for exactly the cycle following edge N+1.
REQ-017 Throughput SHALL be one butterfly per cycle. With start held high, every edge accepts new inputs and done stays high continuously after the 2-cycle fill.
REQ-018 When start=0 at an edge, no new data SHALL enter the pipe. A valid bit SHALL propagate, and the y ports SHALL hold their last value whenever done is low.
REQ-019 Inputs SHALL be sampled only at the clock edge; changes between edges SHALL have no effect.
REQ-020 There SHALL be no combinational path from any input to any output.

Reset
REQ-021 When rst_n=0, all pipeline registers, valid bits, all y outputs and done SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-022 A butterfly in flight when reset asserts SHALL be discarded; done SHALL NOT assert for it after release.
REQ-023 After rst_n rises, the first start=1 edge SHALL produce done two edges later.

Verification
REQ-024 Nominal case:
- Stimulus: x1=(0xFC00, 0), x2=(0x0200, 0), w=(0x00B5, 0xFF4B), start held 1.
- Response after 2 edges: y1_r=0xFD6A, y1_i=0xFE96, y2_r=0xFA96, y2_i=0x016A; done=1.
REQ-025 Identity twiddle: x1=(0x0100, 0x0200), x2=(0x0080, 0xFF80), w=(0x0100, 0) -> y1=(0x0180, 0x0180), y2=(0x0080, 0x0280).
REQ-026 Saturation:
- x1_r=0x7FFF, x2_r=0x7FFF, w=(0x0100, 0), imaginary parts 0 -> y1_r=0x7FFF, y2_r=0x0000.
- x1_r=0x8000, x2_r=0x7FFF, same w -> y2_r=0x8000.
REQ-027 Rounding: x2=(0x0001, 0), w=(0x0080, 0), x1=0 -> product 0x80 rounds to 1, so y1_r=0x0001 and y2_r=0xFFFF.
REQ-028 Handshake and reset:
- A single-cycle start pulse SHALL give a single-cycle done two edges later, with outputs then holding their value.
- Asserting rst_n=0 one edge after start SHALL clear all outputs at once, and done SHALL never assert for that butterfly.
- Back-to-back inputs with start held high SHALL emerge in order, one per cycle.
